// File: rtl/alu_pkg.sv
// Shared opcode encodings and FSM state type for the sequential ALU.
package alu_pkg;

    localparam logic [3:0] OP_AND = 4'b0000;
    localparam logic [3:0] OP_OR  = 4'b0001;
    localparam logic [3:0] OP_ADD = 4'b0010;
    localparam logic [3:0] OP_SUB = 4'b0110;
    localparam logic [3:0] OP_SLT = 4'b0111;
    localparam logic [3:0] OP_NOR = 4'b1100;
    localparam logic [3:0] OP_MUL = 4'b1000;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MUL  = 2'd1,
        S_HOLD = 2'd2
    } state_t;

endpackage

// File: rtl/alu_addsub.sv
// Combinational ripple adder with optional B inversion; serves ADD, SUB and SLT.
module alu_addsub #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    input  logic             i_b_invert,
    input  logic             i_cin,
    output logic [WIDTH-1:0] o_sum,
    output logic             o_cout,
    output logic             o_overflow
);

    logic [WIDTH-1:0] w_b;
    logic             w_carry;
    logic             w_carry_msb;

    // Carry is walked bit by bit; the carry into the MSB is kept for overflow.
    always_comb begin
        w_b         = i_b_invert ? ~i_b : i_b;
        w_carry     = i_cin;
        w_carry_msb = 1'b0;
        o_sum       = '0;
        for (int unsigned i = 0; i < WIDTH; i++) begin
            o_sum[i] = i_a[i] ^ w_b[i] ^ w_carry;
            if (i == WIDTH - 1) begin
                w_carry_msb = w_carry;
            end
            w_carry = (i_a[i] & w_b[i]) | (w_carry & (i_a[i] ^ w_b[i]));
        end
        o_cout     = w_carry;
        o_overflow = w_carry ^ w_carry_msb;
    end

endmodule

// File: rtl/alu_seq.sv
// Registered N-bit ALU with valid/ready handshakes, flags and a multi-cycle
// shift-add multiplier; sits between register read and write-back.
module alu_seq
    import alu_pkg::*;
#(
    parameter int WIDTH  = 32,
    parameter int MUL_EN = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] src1,
    input  logic [WIDTH-1:0] src2,
    input  logic [3:0]       ALU_control,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic             cout,
    output logic             overflow
);

    localparam int CW = $clog2(WIDTH);

    state_t             r_state;
    state_t             w_state_next;
    logic               w_accept;
    logic               w_is_mul;
    logic               w_mul_last;

    logic               w_b_invert;
    logic [WIDTH-1:0]   w_sum;
    logic               w_as_cout;
    logic               w_as_ovf;

    logic [WIDTH-1:0]   w_res;
    logic               w_cout;
    logic               w_ovf;

    logic [2*WIDTH-1:0] r_acc;
    logic [2*WIDTH-1:0] r_mcand;
    logic [2*WIDTH-1:0] w_acc_next;
    logic [WIDTH-1:0]   r_mplier;
    logic [CW-1:0]      r_cnt;

    logic [WIDTH-1:0]   r_result;
    logic               r_zero;
    logic               r_cout;
    logic               r_ovf;

    assign w_accept   = in_valid & in_ready;
    assign w_is_mul   = (ALU_control == OP_MUL) && (MUL_EN != 0);
    assign w_mul_last = (r_cnt == CW'(WIDTH - 1));
    assign w_b_invert = (ALU_control == OP_SUB) || (ALU_control == OP_SLT);
    assign w_acc_next = r_mplier[0] ? (r_acc + r_mcand) : r_acc;

    alu_addsub #(.WIDTH(WIDTH)) u_addsub (
        .i_a        (src1),
        .i_b        (src2),
        .i_b_invert (w_b_invert),
        .i_cin      (w_b_invert),
        .o_sum      (w_sum),
        .o_cout     (w_as_cout),
        .o_overflow (w_as_ovf)
    );

    always_comb begin
        w_res  = '0;
        w_cout = 1'b0;
        w_ovf  = 1'b0;
        case (ALU_control)
            OP_AND: w_res = src1 & src2;
            OP_OR:  w_res = src1 | src2;
            OP_NOR: w_res = ~(src1 | src2);
            OP_ADD, OP_SUB: begin
                w_res  = w_sum;
                w_cout = w_as_cout;
                w_ovf  = w_as_ovf;
            end
            OP_SLT: begin
                w_res[0] = w_sum[WIDTH-1] ^ w_as_ovf;
                w_cout   = w_as_cout;
                w_ovf    = w_as_ovf;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_accept) w_state_next = w_is_mul ? S_MUL : S_HOLD;
            end
            S_MUL: begin
                if (w_mul_last) w_state_next = S_HOLD;
            end
            S_HOLD: begin
                if (w_accept)       w_state_next = w_is_mul ? S_MUL : S_HOLD;
                else if (out_ready) w_state_next = S_IDLE;
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    // in_ready depends combinationally on out_ready so HOLD can reissue without a bubble.
    always_comb begin
        out_valid = (r_state == S_HOLD);
        in_ready  = (r_state == S_IDLE) || ((r_state == S_HOLD) && out_ready);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_acc    <= '0;
            r_mcand  <= '0;
            r_mplier <= '0;
            r_cnt    <= '0;
            r_result <= '0;
            r_zero   <= 1'b0;
            r_cout   <= 1'b0;
            r_ovf    <= 1'b0;
        end else if (w_accept) begin
            if (w_is_mul) begin
                r_mcand  <= {{WIDTH{1'b0}}, src1};
                r_mplier <= src2;
                r_acc    <= '0;
                r_cnt    <= '0;
            end else begin
                r_result <= w_res;
                r_zero   <= ~|w_res;
                r_cout   <= w_cout;
                r_ovf    <= w_ovf;
            end
        end else if (r_state == S_MUL) begin
            r_acc    <= w_acc_next;
            r_mcand  <= r_mcand << 1;
            r_mplier <= r_mplier >> 1;
            r_cnt    <= r_cnt + CW'(1);
            if (w_mul_last) begin
                r_result <= w_acc_next[WIDTH-1:0];
                r_zero   <= ~|w_acc_next[WIDTH-1:0];
                r_cout   <= 1'b0;
                r_ovf    <= |w_acc_next[2*WIDTH-1:WIDTH];
            end
        end
    end

    assign result   = r_result;
    assign zero     = r_zero;
    assign cout     = r_cout;
    assign overflow = r_ovf;

endmodule

// File: tb/tb_alu_seq.sv
// Self-checking bench for alu_seq: vector table plus hand sequences, scored
// through an expected-result queue popped on each output handshake.
module tb_alu_seq;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] src1;
    logic [W-1:0] src2;
    logic [3:0]   ALU_control;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] result;
    logic         zero;
    logic         cout;
    logic         overflow;

    always #5 clk = ~clk;

    alu_seq #(.WIDTH(W), .MUL_EN(1)) dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .src1        (src1),
        .src2        (src2),
        .ALU_control (ALU_control),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .result      (result),
        .zero        (zero),
        .cout        (cout),
        .overflow    (overflow)
    );

    typedef struct {
        logic [3:0]   op;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] res;
        logic         z;
        logic         c;
        logic         v;
        int           lat;
    } vec_t;

    typedef struct {
        logic [W-1:0] res;
        logic         z;
        logic         c;
        logic         v;
        int           lat;
        int           stamp;
    } exp_t;

    exp_t q[$];
    exp_t m_e;
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    bit   front_seen = 1'b0;
    vec_t tbl[16];

    always @(posedge clk) cyc++;

    // Scoreboard monitor: latency on first visibility, values on handshake.
    always @(negedge clk) begin
        if (rst) begin
            q.delete();
            front_seen = 1'b0;
        end else if (out_valid) begin
            if (q.size() == 0) begin
                checks++; errors++;
                $display("FAIL stale_output: out_valid=1 result=%h with nothing outstanding", result);
            end else begin
                if (!front_seen) begin
                    front_seen = 1'b1;
                    checks++;
                    if (cyc - q[0].stamp != q[0].lat) begin
                        errors++;
                        $display("FAIL latency: got %0d cycles, expected %0d", cyc - q[0].stamp, q[0].lat);
                    end
                end
                if (out_ready) begin
                    m_e = q.pop_front();
                    front_seen = 1'b0;
                    checks++;
                    if (result !== m_e.res || zero !== m_e.z || cout !== m_e.c || overflow !== m_e.v) begin
                        errors++;
                        $display("FAIL result: got res=%h z=%b c=%b v=%b, expected res=%h z=%b c=%b v=%b",
                                 result, zero, cout, overflow, m_e.res, m_e.z, m_e.c, m_e.v);
                    end
                end
            end
        end
    end

    function automatic exp_t model(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        exp_t          e;
        logic [W:0]    s;
        logic [2*W-1:0] p;
        e.res = '0; e.c = 1'b0; e.v = 1'b0; e.lat = 1; e.stamp = 0;
        case (op)
            4'b0000: e.res = a & b;
            4'b0001: e.res = a | b;
            4'b1100: e.res = ~(a | b);
            4'b0010: begin
                s = {1'b0, a} + {1'b0, b};
                e.res = s[W-1:0]; e.c = s[W];
                e.v = (a[W-1] == b[W-1]) && (s[W-1] != a[W-1]);
            end
            4'b0110, 4'b0111: begin
                s = {1'b0, a} + {1'b0, ~b} + (W+1)'(1);
                e.c = s[W];
                e.v = (a[W-1] != b[W-1]) && (s[W-1] != a[W-1]);
                if (op == 4'b0110) e.res = s[W-1:0];
                else               e.res = ($signed(a) < $signed(b)) ? W'(1) : '0;
            end
            4'b1000: begin
                p = {{W{1'b0}}, a} * {{W{1'b0}}, b};
                e.res = p[W-1:0]; e.v = |p[2*W-1:W]; e.lat = W + 1;
            end
            default: ;
        endcase
        e.z = (e.res == '0);
        return e;
    endfunction

    function automatic vec_t mk(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                                input logic [W-1:0] res, input logic z, input logic c, input logic v,
                                input int lat);
        vec_t t;
        t.op = op; t.a = a; t.b = b; t.res = res; t.z = z; t.c = c; t.v = v; t.lat = lat;
        return t;
    endfunction

    task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic issue(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b, input exp_t e);
        ALU_control = op; src1 = a; src2 = b; in_valid = 1'b1;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk); #1;
            if (in_ready) begin
                e.stamp = cyc;
                q.push_back(e);
                @(posedge clk); #1;
                in_valid = 1'b0;
                return;
            end
        end
        checks++; errors++;
        $display("FAIL issue_timeout: in_ready=0 for 100 cycles, expected 1");
        in_valid = 1'b0;
    endtask

    task automatic drain();
        for (int i = 0; i < 200 && q.size() != 0; i++) @(negedge clk);
        if (q.size() != 0) begin
            checks++; errors++;
            $display("FAIL drain_timeout: %0d results outstanding, expected 0", q.size());
        end
        @(posedge clk); #1;
    endtask

    initial begin
        exp_t e;
        logic [3:0] ops[7];
        bit bad;

        tbl[0]  = mk(4'b0010, 32'h7FFFFFFF, 32'h00000001, 32'h80000000, 1'b0, 1'b0, 1'b1, 1);
        tbl[1]  = mk(4'b0110, 32'h00000005, 32'h00000005, 32'h00000000, 1'b1, 1'b1, 1'b0, 1);
        tbl[2]  = mk(4'b0111, 32'h80000000, 32'h00000001, 32'h00000001, 1'b0, 1'b1, 1'b1, 1);
        tbl[3]  = mk(4'b0111, 32'h00000001, 32'h80000000, 32'h00000000, 1'b1, 1'b0, 1'b1, 1);
        tbl[4]  = mk(4'b1000, 32'h00001234, 32'h00000010, 32'h00012340, 1'b0, 1'b0, 1'b0, 33);
        tbl[5]  = mk(4'b1000, 32'h00010000, 32'h00010000, 32'h00000000, 1'b1, 1'b0, 1'b1, 33);
        tbl[6]  = mk(4'b0000, 32'hF0F0F0F0, 32'hFF00FF00, 32'hF000F000, 1'b0, 1'b0, 1'b0, 1);
        tbl[7]  = mk(4'b0001, 32'h12340000, 32'h00005678, 32'h12345678, 1'b0, 1'b0, 1'b0, 1);
        tbl[8]  = mk(4'b1100, 32'h00000000, 32'h00000000, 32'hFFFFFFFF, 1'b0, 1'b0, 1'b0, 1);
        tbl[9]  = mk(4'b0010, 32'hFFFFFFFF, 32'h00000001, 32'h00000000, 1'b1, 1'b1, 1'b0, 1);
        tbl[10] = mk(4'b0110, 32'h00000003, 32'h00000005, 32'hFFFFFFFE, 1'b0, 1'b0, 1'b0, 1);
        tbl[11] = mk(4'b0101, 32'hDEADBEEF, 32'h12345678, 32'h00000000, 1'b1, 1'b0, 1'b0, 1);
        tbl[12] = mk(4'b1111, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 1'b1, 1'b0, 1'b0, 1);
        tbl[13] = mk(4'b1000, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000001, 1'b0, 1'b0, 1'b1, 33);
        tbl[14] = mk(4'b0000, 32'hAAAAAAAA, 32'h55555555, 32'h00000000, 1'b1, 1'b0, 1'b0, 1);
        tbl[15] = mk(4'b0110, 32'h80000000, 32'h00000001, 32'h7FFFFFFF, 1'b0, 1'b1, 1'b1, 1);
        ops = '{4'b0000, 4'b0001, 4'b0010, 4'b0110, 4'b0111, 4'b1100, 4'b1000};

        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
        src1 = '0; src2 = '0; ALU_control = 4'b0000;

        // Reset state
        @(negedge clk); @(negedge clk);
        chk("reset_out_valid", W'(out_valid), '0);
        chk("reset_result", result, '0);
        chk("reset_flags", W'({zero, cout, overflow}), '0);
        chk("reset_in_ready", W'(in_ready), W'(1));
        @(posedge clk); #1;
        rst = 1'b0;

        // Vector table, issued back to back
        for (int i = 0; i < 16; i++) begin
            e.res = tbl[i].res; e.z = tbl[i].z; e.c = tbl[i].c; e.v = tbl[i].v;
            e.lat = tbl[i].lat; e.stamp = 0;
            issue(tbl[i].op, tbl[i].a, tbl[i].b, e);
        end
        drain();

        // in_ready stays low for the whole multiply
        issue(4'b1000, 32'h00001234, 32'h00000010, model(4'b1000, 32'h00001234, 32'h00000010));
        bad = 1'b0;
        repeat (W) begin
            @(negedge clk);
            if (in_ready !== 1'b0 || out_valid !== 1'b0) bad = 1'b1;
        end
        chk("mul_busy_in_ready_low", W'(bad), '0);
        drain();

        // Backpressure hold, then same-cycle drain and reissue
        out_ready = 1'b0;
        issue(4'b0010, 32'h00000010, 32'h00000020, model(4'b0010, 32'h00000010, 32'h00000020));
        ALU_control = 4'b0001; src1 = 32'hF0F0F0F0; src2 = 32'h0F0F0F0F; in_valid = 1'b1;
        repeat (3) begin
            @(negedge clk); #1;
            chk("hold_out_valid", W'(out_valid), W'(1));
            chk("hold_in_ready", W'(in_ready), '0);
            chk("hold_result", result, 32'h00000030);
            chk("hold_flags", W'({zero, cout, overflow}), '0);
        end
        @(posedge clk); #1;
        out_ready = 1'b1;
        @(negedge clk); #1;
        chk("b2b_in_ready", W'(in_ready), W'(1));
        e = model(4'b0001, 32'hF0F0F0F0, 32'h0F0F0F0F);
        e.stamp = cyc;
        q.push_back(e);
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(negedge clk); #1;
        chk("b2b_out_valid", W'(out_valid), W'(1));
        chk("b2b_result", result, 32'hFFFFFFFF);
        drain();

        // Reset partway through a multiply
        issue(4'b1000, 32'h00000003, 32'h00000005, model(4'b1000, 32'h00000003, 32'h00000005));
        repeat (8) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("rst_mul_out_valid", W'(out_valid), '0);
        chk("rst_mul_result", result, '0);
        chk("rst_mul_in_ready", W'(in_ready), W'(1));
        chk("rst_mul_flags", W'({zero, cout, overflow}), '0);
        bad = 1'b0;
        repeat (40) begin
            @(negedge clk);
            if (out_valid !== 1'b0) bad = 1'b1;
        end
        chk("rst_mul_no_stale", W'(bad), '0);
        @(posedge clk); #1;

        // Random back-to-back traffic
        for (int i = 0; i < 12; i++) begin
            logic [3:0]   op;
            logic [W-1:0] a;
            logic [W-1:0] b;
            op = ops[$urandom_range(0, 6)];
            a  = $urandom;
            b  = $urandom;
            issue(op, a, b, model(op, a, b));
        end
        drain();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not complete, expected completion");
        $fatal(1);
    end

endmodule

// File: doc/alu_seq.md
Name: alu_seq

Overview:
Parametrised, registered N-bit ALU built around a ripple add/sub core, with valid/ready handshakes on input and output. It extends the single-bit slice with several additions:
- full-width carry, overflow, signed SLT and zero flags
- a NOR operation
- a multi-cycle unsigned shift-add multiply, run by an FSM
- output backpressure

It sits between the register-file read stage and write-back of the lab CPU datapath.

Parameters:
WIDTH, 32, operand/result width in bits (≥2)
MUL_EN, 1, 1 = MUL opcode supported; 0 = MUL treated as illegal opcode

Ports:
clk  input  1  clock, all state updates on rising edge
rst  input  1  synchronous reset, active-high
in_valid  input  1  operands/opcode valid
in_ready  output  1  block can accept an operation this cycle
src1  input  WIDTH  operand A
src2  input  WIDTH  operand B
ALU_control  input  4  opcode: 0000 AND, 0001 OR, 0010 ADD, 0110 SUB, 0111 SLT, 1100 NOR, 1000 MUL
out_valid  output  1  result/flags valid
out_ready  input  1  consumer accepts result
result  output  WIDTH  registered result
zero  output  1  result == 0
cout  output  1  carry out of MSB (ADD/SUB/SLT), else 0
overflow  output  1  signed overflow (ADD/SUB/SLT); MUL: unsigned product exceeds WIDTH bits; else 0

Behaviour:
- Reset (clk edge with rst=1) forces:
  - state IDLE
  - out_valid=0, result=0, zero=0, cout=0, overflow=0
  - multiply accumulator and counter cleared
  - rst overrides any concurrent handshake, including mid-MUL (operation discarded, no out_valid).
- States:
  - IDLE: no result held.
  - MUL: multiply in progress.
  - HOLD: result valid, waiting for out_ready.
- in_ready = (state==IDLE) | (state==HOLD & out_ready). This is a combinational path from out_ready and is intended; it allows back-to-back issue.
- Accept = in_valid & in_ready.
- Single-cycle ops (AND/OR/ADD/SUB/SLT/NOR/illegal):
  - On the accept edge, result and flags are registered and the state goes to HOLD with out_valid=1.
  - Latency is 1 cycle: result is visible in the cycle after acceptance.
- ADD: {cout, sum} = src1 + src2.
- SUB: sum = src1 + ~src2 + 1; cout = carry out (1 when src1 ≥ src2 unsigned).
- overflow (ADD/SUB) = carry-in ^ carry-out of the MSB.
- SLT:
  - result = {WIDTH-1 zeros, sum_msb ^ overflow}, using the SUB datapath.
  - cout and overflow report that subtraction.
- Logic ops and NOR: cout=0, overflow=0.
- Illegal opcode (or MUL with MUL_EN=0): result=0, all flags 0, but zero=1 per the rule below; still completes with 1-cycle latency.
- zero is always computed from the registered result.
- MUL (MUL_EN=1):
  - Accept edge: latch multiplicand=src1 and multiplier=src2; acc=0; cnt=0; state→MUL; out_valid stays 0.
  - Each MUL edge: if the multiplier LSB is 1, acc += multiplicand (2·WIDTH-bit acc). Then multiplicand <<=1, multiplier >>=1, cnt++.
  - At the edge where cnt==WIDTH-1:
    - result = acc[WIDTH-1:0] including the final step
    - overflow = |acc[2W-1:W]
    - cout = 0
    - state→HOLD, out_valid=1
  - Total latency is WIDTH+1 cycles from acceptance. in_ready=0 throughout MUL.
- HOLD:
  - result and flags stay stable while out_ready=0.
  - out_ready=1 with no accept: state→IDLE, out_valid→0.
  - out_ready=1 with accept in the same cycle: the new single-cycle op goes to HOLD again (out_valid stays 1, new data), or a new MUL goes to MUL (out_valid→0).
- in_valid in IDLE is accepted regardless of out_ready.
- Operands and opcode are sampled only on the accept edge; later changes to them are ignored.

Decomposition:
- Shared package alu_pkg:
  - opcode localparams (OP_AND, OP_OR, OP_ADD, OP_SUB, OP_SLT, OP_NOR, OP_MUL)
  - state encoding (S_IDLE, S_MUL, S_HOLD)
- Sub-module alu_addsub: a combinational WIDTH-parametrised ripple adder with B_invert/cin. It outputs sum, cout and overflow, and serves ADD/SUB/SLT.
- FSM, multiply datapath and output registers live in alu_seq.

Test Plan:
1. ADD: src1=0x7FFFFFFF, src2=0x00000001 → result 0x80000000, overflow=1, cout=0, zero=0, out_valid in the cycle after accept.
2. SUB: 5−5 → result 0, zero=1, cout=1, overflow=0.
3. SLT signed:
   - 0x80000000 vs 0x00000001 → result 1.
   - 0x00000001 vs 0x80000000 → result 0, overflow=1.
4. MUL:
   - 0x00001234 × 0x00000010 → 0x00012340 exactly 33 cycles after accept, overflow=0, in_ready=0 throughout.
   - 0x00010000 × 0x00010000 → result 0, overflow=1, zero=1.
5. Backpressure and back-to-back issue:
   - Result held with out_ready=0 for 3 cycles → result, flags and out_valid are stable and in_ready=0; a new in_valid is not accepted.
   - out_ready=1 with a new OR (0xF0F0F0F0, 0x0F0F0F0F) in the same cycle → next cycle shows 0xFFFFFFFF with out_valid=1, no gap.
6. Reset:
   - rst=1 at cycle 10 of a MUL → next cycle IDLE, out_valid=0, result=0, in_ready=1; no stale result ever appears.
   - Illegal opcode 0101 → result 0, zero=1, latency 1.
